// File: rtl/rob_param.sv
// rob_param: reorder buffer with NUM_WB writeback ports, operand lookup, store handshake and branch flush.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module rob_param #(
  parameter int ROB_BIT = 3,
  parameter int NUM_WB  = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [1:0]                 issue_kind,
  input  logic [31:0]                issue_pc,
  input  logic [31:0]                issue_target,
  input  logic [31:0]                issue_value,
  input  logic [4:0]                 issue_rd,
  input  logic                       issue_pred,
  output logic [ROB_BIT-1:0]         issue_entry,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*ROB_BIT-1:0]  wb_entry,
  input  logic [NUM_WB*32-1:0]       wb_value,
  input  logic [ROB_BIT-1:0]         q_entry1,
  input  logic [ROB_BIT-1:0]         q_entry2,
  output logic                       q_ready1,
  output logic                       q_ready2,
  output logic [31:0]                q_value1,
  output logic [31:0]                q_value2,
  output logic                       commit_valid,
  output logic [4:0]                 commit_rd,
  output logic [ROB_BIT-1:0]         commit_entry,
  output logic [31:0]                commit_value,
  output logic                       store_commit,
  input  logic                       store_ack,
  output logic                       flush,
  output logic [31:0]                flush_pc,
  output logic [ROB_BIT:0]           count,
  output logic                       wb_err
);

  localparam int                 DEPTH    = 1 << ROB_BIT;
  localparam logic [ROB_BIT:0]   FULL     = (ROB_BIT+1)'(DEPTH);
  localparam logic [ROB_BIT-1:0] PTR_ONE  = ROB_BIT'(1);
  localparam logic [1:0]         KIND_ALU = 2'd0;
  localparam logic [1:0]         KIND_BR  = 2'd1;
  localparam logic [1:0]         KIND_ST  = 2'd2;
  localparam logic [1:0]         KIND_IMM = 2'd3;

  logic               busy   [DEPTH];
  logic               prep   [DEPTH];
  logic [1:0]         kind   [DEPTH];
  logic [4:0]         rd     [DEPTH];
  logic [31:0]        pc     [DEPTH];
  logic [31:0]        target [DEPTH];
  logic               pred   [DEPTH];
  logic [31:0]        value  [DEPTH];
  logic [ROB_BIT-1:0] head;
  logic [ROB_BIT-1:0] tail;

  logic [ROB_BIT-1:0] wb_ent [NUM_WB];
  logic [31:0]        wb_val [NUM_WB];
  logic [NUM_WB-1:0]  wb_win;
  logic               issue_fire;
  logic               cand;
  logic               retire;

  always_comb begin
    for (int k = 0; k < NUM_WB; k++) begin
      wb_ent[k] = wb_entry[k*ROB_BIT +: ROB_BIT];
      wb_val[k] = wb_value[k*32 +: 32];
    end
  end

  // A channel only counts if no lower-index channel targets the same entry.
  always_comb begin
    wb_win = wb_valid;
    for (int k = 0; k < NUM_WB; k++)
      for (int j = 0; j < NUM_WB; j++)
        if (j < k && wb_valid[j] && wb_ent[j] == wb_ent[k]) wb_win[k] = 1'b0;
  end

  assign issue_ready  = (count < FULL);
  assign issue_fire   = rdy_in & issue_valid & issue_ready;
  assign issue_entry  = tail;

  assign cand         = rdy_in & busy[head] & prep[head];
  assign commit_valid = cand & (kind[head] == KIND_ALU || kind[head] == KIND_IMM);
  assign store_commit = cand & (kind[head] == KIND_ST);
  assign flush        = cand & (kind[head] == KIND_BR) & (value[head][0] != pred[head]);
  assign flush_pc     = flush ? (value[head][0] ? target[head] : pc[head] + 32'd4) : 32'd0;
  assign retire       = cand & ((kind[head] != KIND_ST) | store_ack);
  assign commit_rd    = rd[head];
  assign commit_entry = head;
  assign commit_value = value[head];

  // Returns {ready, value}: stored result, then live writeback, then kind-3 issue.
  function automatic logic [32:0] lookup(input logic [ROB_BIT-1:0] e);
    logic [32:0] r;
    r = '0;
    if (busy[e] && prep[e]) begin
      r = {1'b1, value[e]};
    end else begin
      for (int k = 0; k < NUM_WB; k++)
        if (!r[32] && wb_valid[k] && wb_ent[k] == e) r = {1'b1, wb_val[k]};
      if (!r[32] && issue_fire && issue_kind == KIND_IMM && tail == e)
        r = {1'b1, issue_value};
    end
    return r;
  endfunction

  always_comb begin
    {q_ready1, q_value1} = rst_in ? lookup(q_entry1) : 33'd0;
    {q_ready2, q_value2} = rst_in ? lookup(q_entry2) : 33'd0;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      wb_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        busy[i]   <= 1'b0;
        prep[i]   <= 1'b0;
        kind[i]   <= '0;
        rd[i]     <= '0;
        pc[i]     <= '0;
        target[i] <= '0;
        pred[i]   <= 1'b0;
        value[i]  <= '0;
      end
    end else if (rdy_in) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          busy[i] <= 1'b0;
          prep[i] <= 1'b0;
        end
      end else begin
        for (int k = 0; k < NUM_WB; k++) begin
          if (wb_win[k]) begin
            if (busy[wb_ent[k]] && !prep[wb_ent[k]]) begin
              prep[wb_ent[k]]  <= 1'b1;
              value[wb_ent[k]] <= wb_val[k];
            end else begin
              wb_err <= 1'b1;
            end
          end
        end
        // The tail slot is never busy, so a same-cycle writeback cannot collide with it.
        if (issue_fire) begin
          busy[tail]   <= 1'b1;
          prep[tail]   <= (issue_kind == KIND_IMM);
          kind[tail]   <= issue_kind;
          rd[tail]     <= issue_rd;
          pc[tail]     <= issue_pc;
          target[tail] <= issue_target;
          pred[tail]   <= issue_pred;
          value[tail]  <= (issue_kind == KIND_IMM) ? issue_value : 32'd0;
          tail         <= tail + PTR_ONE;
        end
        if (retire) begin
          busy[head] <= 1'b0;
          prep[head] <= 1'b0;
          head       <= head + PTR_ONE;
        end
        count <= count + (ROB_BIT+1)'(issue_fire) - (ROB_BIT+1)'(retire);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rob_param.sv
// tb_rob_param: directed checks of rob_param with ROB_BIT=3, NUM_WB=2.
`timescale 1ns/1ps
`default_nettype none

module tb_rob_param;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  issue_kind;
  logic [31:0] issue_pc, issue_target, issue_value;
  logic [4:0]  issue_rd;
  logic        issue_pred;
  logic [2:0]  issue_entry;
  logic [1:0]  wb_valid;
  logic [5:0]  wb_entry;
  logic [63:0] wb_value;
  logic [2:0]  q_entry1, q_entry2;
  logic        q_ready1, q_ready2;
  logic [31:0] q_value1, q_value2;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [2:0]  commit_entry;
  logic [31:0] commit_value;
  logic        store_commit;
  logic        store_ack;
  logic        flush;
  logic [31:0] flush_pc;
  logic [3:0]  count;
  logic        wb_err;

  int n_cmp = 0;
  int n_bad = 0;

  rob_param #(.ROB_BIT(3), .NUM_WB(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_kind(issue_kind),
    .issue_pc(issue_pc), .issue_target(issue_target), .issue_value(issue_value),
    .issue_rd(issue_rd), .issue_pred(issue_pred), .issue_entry(issue_entry),
    .wb_valid(wb_valid), .wb_entry(wb_entry), .wb_value(wb_value),
    .q_entry1(q_entry1), .q_entry2(q_entry2), .q_ready1(q_ready1), .q_ready2(q_ready2),
    .q_value1(q_value1), .q_value2(q_value2),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_entry(commit_entry),
    .commit_value(commit_value), .store_commit(store_commit), .store_ack(store_ack),
    .flush(flush), .flush_pc(flush_pc), .count(count), .wb_err(wb_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_in;
    issue_valid  = 1'b0;
    issue_kind   = 2'd0;
    issue_pc     = 32'd0;
    issue_target = 32'd0;
    issue_value  = 32'd0;
    issue_rd     = 5'd0;
    issue_pred   = 1'b0;
    wb_valid     = 2'b00;
    wb_entry     = 6'd0;
    wb_value     = 64'd0;
    store_ack    = 1'b0;
  endtask

  task automatic set_issue(input logic [1:0] k, input logic [31:0] p, input logic [31:0] t,
                           input logic [31:0] v, input logic [4:0] r, input logic pr);
    issue_valid  = 1'b1;
    issue_kind   = k;
    issue_pc     = p;
    issue_target = t;
    issue_value  = v;
    issue_rd     = r;
    issue_pred   = pr;
  endtask

  task automatic set_wb(input int ch, input logic [2:0] ent, input logic [31:0] val);
    wb_valid[ch]          = 1'b1;
    wb_entry[ch*3 +: 3]   = ent;
    wb_value[ch*32 +: 32] = val;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_in;
    rdy_in   = 1'b1;
    rst_in   = 1'b0;
    q_entry1 = 3'd0;
    q_entry2 = 3'd0;
    // Kind-3 offer at tail 0 during reset must not show up on the query port.
    set_issue(2'd3, 32'd0, 32'd0, 32'h55, 5'd1, 1'b0);
    #12;
    check("rst_issue_ready", 32'(issue_ready), 1);
    check("rst_commit_valid", 32'(commit_valid), 0);
    check("rst_store_commit", 32'(store_commit), 0);
    check("rst_flush", 32'(flush), 0);
    check("rst_flush_pc", flush_pc, 0);
    check("rst_q_ready1", 32'(q_ready1), 0);
    check("rst_count", 32'(count), 0);
    check("rst_wb_err", 32'(wb_err), 0);
    clear_in;
    @(negedge clk_in);
    rst_in = 1'b1;
    tick;

    // Fill all eight entries.
    for (int i = 0; i < 8; i++) begin
      set_issue(2'd0, 32'h1000 + 32'(4*i), 32'd0, 32'hdead, 5'(i+1), 1'b0);
      #1 check("fill_entry", 32'(issue_entry), 32'(i));
      tick;
    end
    clear_in;
    #1;
    check("full_count", 32'(count), 8);
    check("full_ready", 32'(issue_ready), 0);
    set_issue(2'd0, 32'h2000, 32'd0, 32'd0, 5'd20, 1'b0);
    tick;
    clear_in;
    #1 check("full_refuse", 32'(count), 8);

    set_wb(0, 3'd0, 32'd5);
    tick;
    clear_in;
    set_issue(2'd0, 32'h2000, 32'd0, 32'd0, 5'd20, 1'b0);
    #1;
    check("c0_valid", 32'(commit_valid), 1);
    check("c0_value", commit_value, 5);
    check("c0_rd", 32'(commit_rd), 1);
    check("c0_entry", 32'(commit_entry), 0);
    check("c0_full_ready", 32'(issue_ready), 0);
    tick;
    clear_in;
    #1;
    check("c0_count", 32'(count), 7);
    check("c0_next_valid", 32'(commit_valid), 0);

    // Two channels hit entry 2 at once: channel 0 wins.
    set_wb(0, 3'd2, 32'd7);
    set_wb(1, 3'd2, 32'd9);
    q_entry2 = 3'd2;
    #1;
    check("fwd_rdy", 32'(q_ready2), 1);
    check("fwd_low", q_value2, 7);
    tick;
    clear_in;
    q_entry1 = 3'd2;
    #1;
    check("dup_rdy", 32'(q_ready1), 1);
    check("dup_val", q_value1, 7);
    check("dup_no_err", 32'(wb_err), 0);
    set_wb(0, 3'd2, 32'd3);
    tick;
    clear_in;
    #1;
    check("late_err", 32'(wb_err), 1);
    check("late_keep", q_value1, 7);

    // Drain entries 1..3 with a freeze in the middle.
    set_wb(0, 3'd1, 32'h11);
    set_wb(1, 3'd3, 32'h33);
    tick;
    clear_in;
    #1;
    check("d1_valid", 32'(commit_valid), 1);
    check("d1_entry", 32'(commit_entry), 1);
    check("d1_value", commit_value, 32'h11);
    tick;
    check("d2_entry", 32'(commit_entry), 2);
    check("d2_value", commit_value, 7);
    check("d2_count", 32'(count), 6);
    rdy_in = 1'b0;
    set_issue(2'd0, 32'h3000, 32'd0, 32'd0, 5'd21, 1'b0);
    set_wb(0, 3'd4, 32'h99);
    #1 check("frz_valid", 32'(commit_valid), 0);
    tick;
    tick;
    clear_in;
    q_entry1 = 3'd4;
    #1;
    check("frz_count", 32'(count), 6);
    check("frz_tail", 32'(issue_entry), 0);
    check("frz_no_wb", 32'(q_ready1), 0);
    rdy_in = 1'b1;
    #1;
    check("thaw_entry", 32'(commit_entry), 2);
    check("thaw_valid", 32'(commit_valid), 1);
    tick;
    check("d3_entry", 32'(commit_entry), 3);
    check("d3_value", commit_value, 32'h33);
    tick;
    check("d3_after_valid", 32'(commit_valid), 0);
    check("d3_after_count", 32'(count), 4);

    // Retire 4..7 and wrap to entry 0 with a kind-3 issue.
    set_wb(0, 3'd4, 32'h44);
    set_wb(1, 3'd5, 32'h55);
    tick;
    clear_in;
    #1;
    check("w4_entry", 32'(commit_entry), 4);
    check("w4_value", commit_value, 32'h44);
    set_wb(0, 3'd6, 32'h66);
    set_wb(1, 3'd7, 32'h77);
    set_issue(2'd3, 32'h500, 32'd0, 32'h1234, 5'd9, 1'b0);
    q_entry1 = 3'd0;
    #1;
    check("k3_q_ready", 32'(q_ready1), 1);
    check("k3_q_value", q_value1, 32'h1234);
    check("k3_entry", 32'(issue_entry), 0);
    tick;
    clear_in;
    #1;
    check("swap_count", 32'(count), 4);
    check("w5_value", commit_value, 32'h55);
    check("k3_stored", q_value1, 32'h1234);
    tick;
    check("w6_value", commit_value, 32'h66);
    tick;
    check("w7_value", commit_value, 32'h77);
    tick;
    check("wrap_entry", 32'(commit_entry), 0);
    check("wrap_value", commit_value, 32'h1234);
    check("wrap_rd", 32'(commit_rd), 9);
    check("wrap_count", 32'(count), 1);
    tick;
    check("empty_valid", 32'(commit_valid), 0);
    check("empty_count", 32'(count), 0);

    // Store handshake at entry 1.
    set_issue(2'd2, 32'h600, 32'd0, 32'd0, 5'd0, 1'b0);
    tick;
    clear_in;
    set_wb(0, 3'd1, 32'hab);
    tick;
    clear_in;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("st_hold", 32'(store_commit), 1);
      check("st_no_commit", 32'(commit_valid), 0);
      check("st_count", 32'(count), 1);
      tick;
    end
    store_ack = 1'b1;
    #1 check("st_ack", 32'(store_commit), 1);
    tick;
    store_ack = 1'b0;
    #1;
    check("st_done", 32'(store_commit), 0);
    check("st_count0", 32'(count), 0);

    // Taken branch predicted not-taken at entry 2.
    set_issue(2'd1, 32'h100, 32'h140, 32'd0, 5'd0, 1'b0);
    tick;
    set_issue(2'd0, 32'h104, 32'd0, 32'd0, 5'd3, 1'b0);
    tick;
    clear_in;
    set_wb(0, 3'd2, 32'd1);
    tick;
    clear_in;
    set_issue(2'd0, 32'h108, 32'd0, 32'd0, 5'd4, 1'b0);
    set_wb(0, 3'd3, 32'h77);
    #1;
    check("br_flush", 32'(flush), 1);
    check("br_pc", flush_pc, 32'h140);
    check("br_no_commit", 32'(commit_valid), 0);
    tick;
    clear_in;
    q_entry1 = 3'd3;
    #1;
    check("br_count", 32'(count), 0);
    check("br_flush_off", 32'(flush), 0);
    check("br_tail", 32'(issue_entry), 0);
    check("br_err_kept", 32'(wb_err), 1);
    check("br_wb_drop", 32'(q_ready1), 0);

    // Correct prediction, then not-taken predicted taken.
    set_issue(2'd1, 32'h300, 32'h380, 32'd0, 5'd0, 1'b0);
    tick;
    set_issue(2'd1, 32'h200, 32'h280, 32'd0, 5'd0, 1'b1);
    tick;
    clear_in;
    set_wb(0, 3'd0, 32'd0);
    set_wb(1, 3'd1, 32'd0);
    tick;
    clear_in;
    #1;
    check("bok_flush", 32'(flush), 0);
    check("bok_commit", 32'(commit_valid), 0);
    check("bok_count", 32'(count), 2);
    tick;
    check("bnt_flush", 32'(flush), 1);
    check("bnt_pc", flush_pc, 32'h204);
    check("bnt_count", 32'(count), 1);
    tick;
    check("bnt_after", 32'(count), 0);

    // Asynchronous reset in the middle of a cycle.
    set_issue(2'd0, 32'h700, 32'd0, 32'd0, 5'd7, 1'b0);
    tick;
    tick;
    clear_in;
    check("pre_rst_count", 32'(count), 2);
    #3 rst_in = 1'b0;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_ready", 32'(issue_ready), 1);
    check("arst_err", 32'(wb_err), 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    tick;
    check("post_rst_count", 32'(count), 0);
    check("post_rst_valid", 32'(commit_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
